// File: rtl/game_timer.sv
// game_timer: BCD countdown round timer for the whack-a-mole game.
//
// Samples the clk_divider 1 Hz square wave as data on clk_in and turns each
// rising edge into a one-cycle second tick. On each tick it counts a round
// down from GAME_SECONDS to 00. It also supports pause and abort, and flags
// the final seconds and the end of the round.
//
// Ports
//   clk_in     in   100 MHz system clock, posedge
//   rst_n      in   asynchronous active-low reset
//   clk_1Hz    in   1 Hz square wave, asynchronous, synchronized here
//   start      in   level; starts a round from IDLE or DONE
//   pause      in   level; holds the countdown during a round
//   abort      in   level; returns to IDLE from any state
//   time_tens  out  BCD tens digit of remaining seconds
//   time_ones  out  BCD ones digit of remaining seconds
//   running    out  high in RUN
//   warn       out  high in RUN/PAUSED while remaining is 1..WARN_SECONDS
//   time_up    out  one-cycle pulse when a round completes
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | no round active, digits 00
// RUN     | counting down on each second tick
// PAUSED  | round frozen, ticks are dropped
// DONE    | round finished, digits held at 00
module game_timer #(
   parameter int GAME_SECONDS = 30,
   parameter int WARN_SECONDS = 5
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       clk_1Hz,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   output logic [3:0] time_tens,
   output logic [3:0] time_ones,
   output logic       running,
   output logic       warn,
   output logic       time_up
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [3:0] LP_LOAD_TENS = 4'(GAME_SECONDS / 10);
   localparam logic [3:0] LP_LOAD_ONES = 4'(GAME_SECONDS % 10);
   localparam logic [6:0] LP_WARN      = 7'(WARN_SECONDS);

   logic       r_s1, r_s2, r_s3;
   logic [1:0] r_state;
   logic [3:0] r_tens, r_ones;
   logic       r_running, r_warn, r_time_up;

   logic       w_sec_tick;
   logic       w_last_sec;
   logic [1:0] w_state_nxt;
   logic [3:0] w_tens_nxt, w_ones_nxt;
   logic       w_time_up_nxt;
   logic [6:0] w_remaining_nxt;
   logic       w_warn_nxt;
   logic       w_active_nxt;

   // r_s1/r_s2 form the synchronizer. r_s3 remembers the previous
   // synchronized level, so a tick fires once per rising edge only.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= clk_1Hz;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_sec_tick = r_s2 & ~r_s3;
   assign w_last_sec = (r_tens == 4'd0) && (r_ones == 4'd1);

   always_comb begin
      w_state_nxt   = r_state;
      w_tens_nxt    = r_tens;
      w_ones_nxt    = r_ones;
      w_time_up_nxt = 1'b0;
      if (abort) begin
         w_state_nxt = ST_IDLE;
         w_tens_nxt  = 4'd0;
         w_ones_nxt  = 4'd0;
      end else if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
         w_state_nxt = ST_RUN;
         w_tens_nxt  = LP_LOAD_TENS;
         w_ones_nxt  = LP_LOAD_ONES;
      end else if (r_state == ST_RUN && pause) begin
         // A tick in this same cycle is dropped; pause takes priority.
         w_state_nxt = ST_PAUSED;
      end else if (r_state == ST_RUN && w_sec_tick) begin
         if (w_last_sec) begin
            w_state_nxt   = ST_DONE;
            w_tens_nxt    = 4'd0;
            w_ones_nxt    = 4'd0;
            w_time_up_nxt = 1'b1;
         end else if (r_ones != 4'd0) begin
            w_ones_nxt = r_ones - 4'd1;
         end else begin
            w_ones_nxt = 4'd9;
            w_tens_nxt = r_tens - 4'd1;
         end
      end else if (r_state == ST_PAUSED && !pause) begin
         w_state_nxt = ST_RUN;
      end
   end

   // Flags are computed from next-state values, so that after each edge
   // they agree with the state and digits registered on that same edge.
   assign w_remaining_nxt = (7'(w_tens_nxt) * 7'd10) + 7'(w_ones_nxt);
   assign w_active_nxt    = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSED);
   assign w_warn_nxt      = w_active_nxt && (w_remaining_nxt != 7'd0) &&
                            (w_remaining_nxt <= LP_WARN);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_tens    <= 4'd0;
         r_ones    <= 4'd0;
         r_running <= 1'b0;
         r_warn    <= 1'b0;
         r_time_up <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tens    <= w_tens_nxt;
         r_ones    <= w_ones_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_warn    <= w_warn_nxt;
         r_time_up <= w_time_up_nxt;
      end
   end

   assign time_tens = r_tens;
   assign time_ones = r_ones;
   assign running   = r_running;
   assign warn      = r_warn;
   assign time_up   = r_time_up;

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;

   localparam int GS = 12;
   localparam int WS = 3;

   logic       clk_in = 1'b0;
   logic       rst_n  = 1'b0;
   logic       clk_1Hz = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] time_tens, time_ones;
   logic       running, warn, time_up;

   int tests = 0;
   int fails = 0;
   int tu_cnt = 0;

   game_timer #(.GAME_SECONDS(GS), .WARN_SECONDS(WS)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .clk_1Hz(clk_1Hz),
      .start(start), .pause(pause), .abort(abort),
      .time_tens(time_tens), .time_ones(time_ones),
      .running(running), .warn(warn), .time_up(time_up)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: remaining seconds as an integer, a mode, and the
   // history of clk_1Hz samples. A rise sampled at edge n-2 after a low at
   // edge n-3 counts as a second at edge n.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
   int m_mode = M_IDLE;
   int m_rem  = 0;
   int m_tu   = 0;
   bit h0 = 0, h1 = 0, h2 = 0;

   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_IDLE; m_rem = 0; m_tu = 0;
         h0 = 0; h1 = 0; h2 = 0;
      end else begin
         bit tick;
         tick = h1 && !h2;
         h2 = h1; h1 = h0; h0 = clk_1Hz;
         m_tu = 0;
         if (abort) begin
            m_mode = M_IDLE; m_rem = 0;
         end else if ((m_mode == M_IDLE || m_mode == M_DONE) && start) begin
            m_mode = M_RUN; m_rem = GS;
         end else if (m_mode == M_RUN && pause) begin
            m_mode = M_PAUSED;
         end else if (m_mode == M_RUN && tick) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_mode = M_DONE; m_tu = 1;
            end
         end else if (m_mode == M_PAUSED && !pause) begin
            m_mode = M_RUN;
         end
      end
   end

   always @(negedge clk_in) begin
      if (rst_n) begin
         check("tens",    int'(time_tens), m_rem / 10);
         check("ones",    int'(time_ones), m_rem % 10);
         check("running", int'(running),   int'(m_mode == M_RUN));
         check("warn",    int'(warn),
               int'((m_mode == M_RUN || m_mode == M_PAUSED) && m_rem >= 1 && m_rem <= WS));
         check("time_up", int'(time_up),   m_tu);
         if (time_up) tu_cnt++;
      end
   end

   task automatic sec_rise();
      clk_1Hz = 1'b1;
      repeat (5) @(negedge clk_in);
      clk_1Hz = 1'b0;
      repeat (5) @(negedge clk_in);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk_in);
      check("reset_tens",    int'(time_tens), 0);
      check("reset_ones",    int'(time_ones), 0);
      check("reset_running", int'(running),   0);
      check("reset_warn",    int'(warn),      0);
      check("reset_time_up", int'(time_up),   0);
      rst_n = 1'b1;
      @(negedge clk_in);

      // idle with the 1 Hz input toggling
      repeat (3) sec_rise();
      check("idle_ones", int'(time_ones), 0);
      check("idle_tu_cnt", tu_cnt, 0);

      // start then tick latency
      pulse_start();
      check("load_tens", int'(time_tens), 1);
      check("load_ones", int'(time_ones), 2);
      check("load_running", int'(running), 1);
      clk_1Hz = 1'b1;
      @(posedge clk_in); @(posedge clk_in); #1;
      check("lat_edge2_ones", int'(time_ones), 2);
      @(posedge clk_in); #1;
      check("lat_edge3_ones", int'(time_ones), 1);
      repeat (1000) @(negedge clk_in);
      check("held_high_ones", int'(time_ones), 1);
      clk_1Hz = 1'b0;
      repeat (5) @(negedge clk_in);

      sec_rise();
      sec_rise();
      check("borrow_tens", int'(time_tens), 0);
      check("borrow_ones", int'(time_ones), 9);
      sec_rise();
      sec_rise();
      check("at07_ones", int'(time_ones), 7);

      // pause across three rises
      pause = 1'b1;
      repeat (3) sec_rise();
      check("paused_ones", int'(time_ones), 7);
      check("paused_running", int'(running), 0);
      pause = 1'b0;
      @(negedge clk_in);
      sec_rise();
      check("resume_ones", int'(time_ones), 6);
      sec_rise();
      check("at05_ones", int'(time_ones), 5);

      // pause lands in the same cycle as the tick
      clk_1Hz = 1'b1;
      @(negedge clk_in); @(negedge clk_in);
      pause = 1'b1;
      @(negedge clk_in);
      check("coinc_ones", int'(time_ones), 5);
      check("coinc_running", int'(running), 0);
      repeat (3) @(negedge clk_in);
      clk_1Hz = 1'b0;
      pause = 1'b0;
      repeat (2) @(negedge clk_in);
      check("coinc_resume_running", int'(running), 1);
      check("coinc_resume_ones", int'(time_ones), 5);
      sec_rise();
      check("at04_ones", int'(time_ones), 4);
      check("at04_warn", int'(warn), 0);

      // abort at 04
      abort = 1'b1;
      @(negedge clk_in);
      abort = 1'b0;
      check("abort_ones", int'(time_ones), 0);
      check("abort_running", int'(running), 0);
      check("abort_warn", int'(warn), 0);
      @(negedge clk_in);

      // reset mid-round
      pulse_start();
      repeat (3) sec_rise();
      check("pre_reset_ones", int'(time_ones), 9);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tens", int'(time_tens), 0);
      check("rst_mid_ones", int'(time_ones), 0);
      check("rst_mid_running", int'(running), 0);
      check("rst_mid_time_up", int'(time_up), 0);
      @(negedge clk_in);
      rst_n = 1'b1;
      @(negedge clk_in);
      check("after_rst_tu_cnt", tu_cnt, 0);

      // full round
      pulse_start();
      for (int i = 0; i < GS; i++) begin
         int rem;
         sec_rise();
         rem = GS - 1 - i;
         check("round_tens", int'(time_tens), rem / 10);
         check("round_ones", int'(time_ones), rem % 10);
         check("round_warn", int'(warn), int'(rem >= 1 && rem <= WS));
      end
      check("done_running", int'(running), 0);
      check("done_tu_cnt", tu_cnt, 1);
      repeat (20) @(negedge clk_in);
      check("done_hold_ones", int'(time_ones), 0);
      check("done_tu_still_one", tu_cnt, 1);

      // held start reloads immediately from DONE
      start = 1'b1;
      @(negedge clk_in);
      check("reload_tens", int'(time_tens), 1);
      check("reload_ones", int'(time_ones), 2);
      check("reload_running", int'(running), 1);
      sec_rise();
      check("start_ignored_ones", int'(time_ones), 1);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk_in);
      abort = 1'b0;
      @(negedge clk_in);
      check("final_tu_cnt", tu_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
